// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM state type.
package mdu_pkg;

  localparam int unsigned MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } mdu_state_e;

endpackage

// File: rtl/mdu_core_arith.sv
// Combinational signed/unsigned product, quotient and remainder with
// divide-by-zero and signed-overflow flags.
module mdu_core_arith #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               is_signed_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               div_zero_o,
  output logic               div_ovf_o
);

  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, divisor;
  logic [WIDTH-1:0]   q_mag, r_mag;

  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  always_comb begin
    a_ext  = is_signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    b_ext  = is_signed_i ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    prod_o = a_ext * b_ext;
  end

  always_comb begin
    a_neg      = is_signed_i & a_i[WIDTH-1];
    b_neg      = is_signed_i & b_i[WIDTH-1];
    a_mag      = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag      = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero_o = (b_i == '0);
    div_ovf_o  = is_signed_i && (a_i == MostNeg) && (b_i == '1);
    // Keep the divider well defined; the result is discarded on divide by zero.
    divisor    = div_zero_o ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    quot_o     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem_o      = a_neg ? (~r_mag + 1'b1) : r_mag;
    if (div_ovf_o) begin
      quot_o = MostNeg;
      rem_o  = '0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers; results
// are held in pending registers and committed when the latency counter expires.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  if ((2 ** CNT_W) <= MULT_CYCLES || (2 ** CNT_W) <= DIV_CYCLES ||
      MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_cnt_w_check
    $error("mult_div_unit: CNT_W too small or cycle count below 1");
  end

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic               commit_q, commit_d;

  logic               is_signed;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_zero, div_ovf;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_core_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .a_i        (a),
    .b_i        (b),
    .is_signed_i(is_signed),
    .prod_o     (prod),
    .quot_o     (quot),
    .rem_o      (rem),
    .div_zero_o (div_zero),
    .div_ovf_o  (div_ovf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    commit_d  = commit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              {hi_pend_d, lo_pend_d} = prod;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              busy_d   = 1'b1;
              state_d  = StRun;
            end
            MDU_DIV, MDU_DIVU: begin
              hi_pend_d = div_ovf ? '0 : rem;
              lo_pend_d = quot;
              // Divide by zero still stalls but leaves HI/LO untouched.
              commit_d  = !div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = StRun;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
          if (commit_q) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      commit_q  <= commit_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int ncyc;

  mult_div_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns 1 ns after the accepting edge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0; op = 3'd0; a = '0; b = '0;
  endtask

  // Counts cycles with busy high, bounded at 50.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    do_op(3'd5, 32'h1234, 32'h0);
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected %h", hi, 32'h1234); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_after_mthi: got %h expected %h", hi, 32'h0); end
  endtask

  task automatic test_mult();
    do_op(3'd1, 32'hFFFF_FFFF, 32'd3);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_no_early_hi: got %h expected %h", hi, 32'h0); end
    wait_idle(ncyc);
    checks++; if (ncyc !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", ncyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
    do_op(3'd2, 32'hFFFF_FFFF, 32'd3);
    wait_idle(ncyc);
    checks++; if (hi !== 32'h2) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'h2); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
  endtask

  task automatic test_div();
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(ncyc);
    checks++; if (ncyc !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", ncyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    do_op(3'd4, 32'd7, 32'd2);
    wait_idle(ncyc);
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo, 32'd3); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected %h", hi, 32'd1); end
  endtask

  task automatic test_div_special();
    do_op(3'd5, 32'hAA, 32'h0);
    do_op(3'd6, 32'hBB, 32'h0);
    do_op(3'd3, 32'd100, 32'd0);
    wait_idle(ncyc);
    checks++; if (ncyc !== 10) begin errors++; $display("FAIL divzero_busy_cycles: got %0d expected 10", ncyc); end
    checks++; if (hi !== 32'hAA) begin errors++; $display("FAIL divzero_hi: got %h expected %h", hi, 32'hAA); end
    checks++; if (lo !== 32'hBB) begin errors++; $display("FAIL divzero_lo: got %h expected %h", lo, 32'hBB); end
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(ncyc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected %h", hi, 32'h0); end
  endtask

  task automatic test_back_to_back();
    int total;
    do_op(3'd1, 32'd2, 32'd3);   // now in busy cycle 1
    step();                      // busy cycle 2
    do_op(3'd4, 32'd9, 32'd4);   // ignored; now in busy cycle 3
    wait_idle(ncyc);
    total = ncyc + 2;
    checks++; if (total !== 5) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 5", total); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL busy_start_lo: got %h expected %h", lo, 32'd6); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_start_hi: got %h expected %h", hi, 32'd0); end
    do_op(3'd4, 32'd9, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    wait_idle(ncyc);
    checks++; if (lo !== 32'd2) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'd2); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'd1); end
  endtask

  task automatic test_reset_run();
    do_op(3'd1, 32'd5, 32'd5);
    step();
    step();                      // busy cycle 3
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b expected 0", busy); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_run_lo: got %h expected %h", lo, 32'h0); end
    repeat (12) step();
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_run_no_commit: got %h expected %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_stays_idle: got %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_back_to_back();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU. It accepts one operation per start pulse and models multi-cycle latency with a busy flag, which the hazard controller uses to stall HI/LO-dependent instructions. It supersedes fixed single-cycle arithmetic with configurable width and latency, signed and unsigned modes, and direct HI/LO writes.

Parameters:
WIDTH, 32, operand and HI/LO register width in bits
MULT_CYCLES, 5, busy cycles for MULT/MULTU (minimum 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (minimum 1)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request; samples op, a, b
op  input  3  operation code (see package)
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt
busy  output  1  operation in progress, registered
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset clears hi, lo, busy, counter and pending result regs to 0.
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and NOP are ignored.
- States: IDLE and RUN.
- Accepting a start: start is accepted only in IDLE, i.e. when busy=0. A start while busy=1 is ignored, with no state change. The stall logic guarantees this does not occur, and the bench checks that it is ignored.
- MULT/MULTU at an accepted start:
  - Compute the 2*WIDTH-bit product: signed for MULT, zero-extended for MULTU.
  - Latch {hi_next, lo_next} = product into pending regs.
  - Load counter = MULT_CYCLES; go to RUN; busy=1 from the next cycle.
- DIV/DIVU at an accepted start:
  - lo_next = quotient, hi_next = remainder. Signed ops truncate toward zero; remainder takes the sign of the dividend.
  - Load counter = DIV_CYCLES; go to RUN.
  - If b==0: still go busy for DIV_CYCLES, but hi/lo are left unchanged at completion.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- RUN: counter decrements each cycle. On the edge where counter goes 1->0, commit hi<=hi_next and lo<=lo_next, busy<=0, return to IDLE.
  - busy is high for exactly N consecutive cycles (N = MULT_CYCLES or DIV_CYCLES), starting the cycle after start.
  - New hi/lo are visible in the first cycle busy=0.
- MTHI/MTLO in IDLE: write a into hi or lo at the next edge. No busy assertion; visible the next cycle.
- hi/lo outputs are register values only and never show pending results.
- Back-to-back: a start in the first cycle busy=0 is accepted. The previous result is already committed, and the new op uses the committed values only for MTHI/MTLO.
- Reset during RUN: the operation is abandoned, no commit, hi/lo return to 0.
- Counter width is checked by an assertion at elaboration (generate-time error if violated).

Decomposition:
- Shared package mdu_pkg holds:
  - the op code localparams (MDU_NOP..MDU_MTLO);
  - the MDU_OP_W=3 constant, also used by the Controller for decode.
- One natural sub-module, mdu_core_arith: combinational signed/unsigned product, quotient and remainder, including the divide-by-zero and overflow flags.
- The parent mult_div_unit holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- Reset: hold reset 2 cycles -> hi=0, lo=0, busy=0; after an MTHI 0x1234 write, assert reset -> hi=0 next cycle.
- MULT a=0xFFFFFFFF (-1), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFD. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFD.
- DIV a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- Divide by zero: preload hi=0xAA, lo=0xBB via MTHI/MTLO, then DIV b=0 -> busy 10 cycles, hi=0xAA, lo=0xBB afterwards. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- Start while busy: MULT 2*3, then DIVU 9/4 on cycle 2 of busy -> DIVU ignored, busy falls after 5 cycles, lo=6, hi=0. DIVU issued on the first idle cycle -> lo=2, hi=1.
- Reset mid-RUN: MULT 5*5, assert reset on busy cycle 3 -> busy=0, lo=0 next cycle, and no later commit of 25.
